shared_adder_arbiter: RTL and testbench
=======================================

// Module: shared_adder_arbiter
// PURPOSE
//  Shares one internal 32-bit ripple-carry adder between two requesters.
//  Each requester offers an operand pair on a valid/ready handshake.
//  The block grants one requester, runs the add as a multicycle path of
//  ADD_CYCLES clocks, and returns a 40-bit zero-extended result tagged
//  with the requester ID. It sits between the operand sources and the
//  result consumer, and replaces duplicated per-requester adders.
// PARAMETERS
//  ADD_CYCLES  2  clocks the operand registers are held before the sum is
//                 sampled; legal range 1..15
//  FIXED_PRIO  0  0 = round-robin arbitration; 1 = req0 always wins
// PORTS
//  clk           in   1   clock; all logic is on the rising edge
//  RST           in   1   synchronous reset, active-high
//  req0_valid    in   1   requester 0 has an operand pair
//  req0_ready    out  1   requester 0 pair is accepted this cycle
//  req0_a        in   32  requester 0 operand A
//  req0_b        in   32  requester 0 operand B
//  req1_valid    in   1   requester 1 has an operand pair
//  req1_ready    out  1   requester 1 pair is accepted this cycle
//  req1_a        in   32  requester 1 operand A
//  req1_b        in   32  requester 1 operand B
//  rsp_valid     out  1   a result is available
//  rsp_ready     in   1   the consumer takes the result
//  rsp_id        out  1   ID of the requester that owns the result
//  rsp_result    out  40  {7'b0, cout, sum[31:0]}
// BEHAVIOUR
//  - Reset (RST=1 at a rising edge):
//    - state goes to IDLE.
//    - rsp_valid=0, rsp_id=0, rsp_result=0.
//    - Operand registers are cleared; cycle counter is cleared.
//    - Round-robin pointer rr=0, so req0 is favoured first.
//    - Reset wins over every other event. An op in flight is dropped and
//      no response is produced.
//  - States: IDLE, EXEC, RESP. There is no other state; an illegal
//    encoding returns to IDLE.
//  - IDLE:
//    - Grant is combinational.
//      - If only one requester has valid=1, that requester is granted.
//      - If both have valid=1: FIXED_PRIO=1 grants req0; otherwise req<rr>
//        is granted.
//    - reqN_ready = (state==IDLE) & grantN. At most one ready is high per
//      cycle.
//    - When valid&ready at an edge:
//      - A/B and the ID are captured into the operand registers.
//      - cnt = ADD_CYCLES-1; go to EXEC.
//  - EXEC:
//    - Both ready outputs are 0. The operand registers are held stable
//      and feed the adder (Cin=0).
//    - cnt decrements each cycle.
//    - At the edge where cnt==0: rsp_result <= {7'b0, cout, sum};
//      rsp_id <= ID; rsp_valid <= 1; go to RESP.
//  - RESP:
//    - rsp_valid=1; rsp_id and rsp_result are held stable. Both ready
//      outputs are 0.
//    - When rsp_ready=1 at an edge:
//      - rsp_valid <= 0; go to IDLE.
//      - rr <= ~rsp_id, so the other requester is favoured next.
//  - Latency: handshake at edge E0 -> rsp_valid=1 after edge
//    E0+ADD_CYCLES. Peak throughput is 1 op per ADD_CYCLES+2 clocks.
//  - A requester that drops valid without a handshake has nothing
//    captured. Operands are sampled only on a handshake.
//  - Width rule: the sum is 33 bits (carry included); bits 39:33 are 0.
//    The adder cannot overflow the 40-bit result.
//  - Simultaneous events:
//    - rsp_ready in IDLE or EXEC is ignored.
//    - A requester that is not granted keeps its valid and is served
//      later; it is never starved in round-robin mode.
// TESTING
//  1. req0: A=32'hFFFF_FFFF, B=32'h1, ADD_CYCLES=2 -> rsp_valid 2 clocks
//     after the handshake; rsp_result=40'h01_0000_0000, rsp_id=0.
//  2. Both valid held high, rsp_ready=1, FIXED_PRIO=0 -> grant order
//     0,1,0,1. No cycle has both ready=1. Results match A+B per ID.
//  3. FIXED_PRIO=1, both valid held high -> every response has rsp_id=0;
//     req1_ready is never 1.
//  4. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and
//     rsp_result are stable; req0_ready=req1_ready=0 throughout.
//  5. RST=1 one cycle mid-EXEC (req1 A=5, B=7) -> no response; outputs
//     are 0. The next op A=3, B=4 returns 40'h7 with rsp_id=0.
//  6. ADD_CYCLES=3, A=32'h8000_0000, B=32'h8000_0000 -> response exactly
//     3 clocks after the handshake; rsp_result=40'h01_0000_0000.

Source files
------------

// File: rtl/shared_adder_arbiter.sv
// Shared 32-bit ripple-carry adder with a two-requester arbiter.
// One op in flight at a time: IDLE grants, EXEC holds operands for
// ADD_CYCLES clocks (multicycle path), RESP holds the tagged result.
module shared_adder_arbiter #(
  parameter int ADD_CYCLES = 2,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [39:0] rsp_result
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        id_q, id_d;
  logic        rr_q, rr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [39:0] rsp_result_q, rsp_result_d;

  logic        grant0, grant1;
  logic [31:0] sum;
  logic [32:0] carry;

  // Ripple-carry chain fed only by the held operand registers (Cin=0);
  // it is allowed ADD_CYCLES clocks to settle before being sampled.
  assign carry[0] = 1'b0;
  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]     = a_q[i] ^ b_q[i] ^ carry[i];
    assign carry[i+1] = (a_q[i] & b_q[i]) | (carry[i] & (a_q[i] ^ b_q[i]));
  end

  // Arbitration: lone requester wins; on contention FIXED_PRIO or rr decides.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | FIXED_PRIO | ~rr_q);
    grant1 = req1_valid & ~grant0;
  end

  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

  // Next-state logic: capture on handshake, count down, publish, await consumer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rr_d         = rr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          a_d     = grant1 ? req1_a : req0_a;
          b_d     = grant1 ? req1_b : req0_b;
          id_d    = grant1;
          cnt_d   = 4'(ADD_CYCLES - 1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_result_d = {7'b0, carry[32], sum};
          rsp_id_d     = id_q;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_d        = ~rsp_id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any op in flight.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rr_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rr_q         <= rr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed bench: three instances (round-robin AC=2, fixed-prio AC=2,
// round-robin AC=3) driven from per-instance input arrays.
module tb_shared_adder_arbiter;
  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        v0[3], v1[3], rrdy[3];
  logic [31:0] a0[3], b0[3], a1[3], b1[3];
  logic        rdy0[3], rdy1[3], rv[3], rid[3];
  logic [39:0] rres[3];

  int n_vec = 0, n_err = 0;
  int both_cnt, r1_cnt, got;
  logic        got_id[8];
  logic [39:0] got_res[8];

  always #5 clk = ~clk;

  shared_adder_arbiter #(.ADD_CYCLES(2), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .RST(RST),
    .req0_valid(v0[0]), .req0_ready(rdy0[0]), .req0_a(a0[0]), .req0_b(b0[0]),
    .req1_valid(v1[0]), .req1_ready(rdy1[0]), .req1_a(a1[0]), .req1_b(b1[0]),
    .rsp_valid(rv[0]), .rsp_ready(rrdy[0]), .rsp_id(rid[0]), .rsp_result(rres[0]));

  shared_adder_arbiter #(.ADD_CYCLES(2), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .RST(RST),
    .req0_valid(v0[1]), .req0_ready(rdy0[1]), .req0_a(a0[1]), .req0_b(b0[1]),
    .req1_valid(v1[1]), .req1_ready(rdy1[1]), .req1_a(a1[1]), .req1_b(b1[1]),
    .rsp_valid(rv[1]), .rsp_ready(rrdy[1]), .rsp_id(rid[1]), .rsp_result(rres[1]));

  shared_adder_arbiter #(.ADD_CYCLES(3), .FIXED_PRIO(1'b0)) u_ac3 (
    .clk(clk), .RST(RST),
    .req0_valid(v0[2]), .req0_ready(rdy0[2]), .req0_a(a0[2]), .req0_b(b0[2]),
    .req1_valid(v1[2]), .req1_ready(rdy1[2]), .req1_a(a1[2]), .req1_b(b1[2]),
    .rsp_valid(rv[2]), .rsp_ready(rrdy[2]), .rsp_id(rid[2]), .rsp_result(rres[2]));

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  // Offer one pair and return just after the handshake edge with valid dropped.
  task automatic hs(input int k, input bit id, input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    if (id) begin v1[k] = 1'b1; a1[k] = a; b1[k] = b; end
    else    begin v0[k] = 1'b1; a0[k] = a; b0[k] = b; end
    #1;
    while (!(id ? rdy1[k] : rdy0[k]) && t < 20) begin tick(); t++; end
    chk("hs_timeout", 64'(t >= 20), 64'd0);
    tick();
    v0[k] = 1'b0; v1[k] = 1'b0;
  endtask

  task automatic op(input int k, input bit id, input logic [31:0] a, input logic [31:0] b,
                    input int exp_lat, input logic [39:0] exp_res);
    int lat = 0;
    hs(k, id, a, b);
    while (!rv[k] && lat < 20) begin tick(); lat++; end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("rsp_id", 64'(rid[k]), 64'(id));
    chk("rsp_result", 64'(rres[k]), 64'(exp_res));
    rrdy[k] = 1'b1;
    tick();
    rrdy[k] = 1'b0;
    chk("rsp_valid_drop", 64'(rv[k]), 64'd0);
  endtask

  // Both requesters held valid with rsp_ready=1; collect n responses.
  task automatic stream(input int k, input int n);
    int cyc = 0;
    both_cnt = 0; r1_cnt = 0; got = 0;
    v0[k] = 1'b1; a0[k] = 32'd10;         b0[k] = 32'd20;
    v1[k] = 1'b1; a1[k] = 32'hFFFF_FFFF;  b1[k] = 32'hFFFF_FFFF;
    rrdy[k] = 1'b1;
    #1;
    while (got < n && cyc < 200) begin
      if (rdy0[k] && rdy1[k]) both_cnt++;
      if (rdy1[k]) r1_cnt++;
      if (rv[k]) begin got_id[got] = rid[k]; got_res[got] = rres[k]; got++; end
      if (got < n) begin tick(); cyc++; end
    end
    chk("stream_timeout", 64'(cyc >= 200), 64'd0);
    v0[k] = 1'b0; v1[k] = 1'b0;
    tick();
    rrdy[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      v0[k] = 0; v1[k] = 0; rrdy[k] = 0; a0[k] = 0; b0[k] = 0; a1[k] = 0; b1[k] = 0;
    end
    repeat (3) tick();
    RST = 1'b0;
    tick();

    // reset state
    chk("rst_valid", 64'(rv[0]), 64'd0);
    chk("rst_id", 64'(rid[0]), 64'd0);
    chk("rst_result", 64'(rres[0]), 64'd0);
    chk("rst_ready", 64'({rdy0[0], rdy1[0]}), 64'd0);

    // carry out of bit 31, AC=2
    op(0, 1'b0, 32'hFFFF_FFFF, 32'h1, 2, 40'h01_0000_0000);

    // round-robin ordering from a fresh reset
    RST = 1'b1; tick(); RST = 1'b0; tick();
    stream(0, 4);
    chk("rr_both_ready", 64'(both_cnt), 64'd0);
    chk("rr_id0", 64'(got_id[0]), 64'd0);
    chk("rr_id1", 64'(got_id[1]), 64'd1);
    chk("rr_id2", 64'(got_id[2]), 64'd0);
    chk("rr_id3", 64'(got_id[3]), 64'd1);
    chk("rr_res0", 64'(got_res[0]), 64'h00_0000_001E);
    chk("rr_res1", 64'(got_res[1]), 64'h01_FFFF_FFFE);
    chk("rr_res2", 64'(got_res[2]), 64'h00_0000_001E);
    chk("rr_res3", 64'(got_res[3]), 64'h01_FFFF_FFFE);

    // fixed priority: req0 always wins
    stream(1, 3);
    chk("fp_r1_ready", 64'(r1_cnt), 64'd0);
    chk("fp_both_ready", 64'(both_cnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("fp_id", 64'(got_id[i]), 64'd0);
      chk("fp_res", 64'(got_res[i]), 64'h00_0000_001E);
    end

    // response held under backpressure, other requester waiting
    begin
      int lat = 0;
      hs(0, 1'b0, 32'd1, 32'd2);
      while (!rv[0] && lat < 20) begin tick(); lat++; end
      chk("bp_latency", 64'(lat), 64'd2);
      v1[0] = 1'b1; a1[0] = 32'd9; b1[0] = 32'd9;
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("bp_hold", 64'({rv[0], rid[0], rdy0[0], rdy1[0], rres[0]}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 40'd3}));
      end
      rrdy[0] = 1'b1; v1[0] = 1'b0;
      tick();
      rrdy[0] = 1'b0;
      chk("bp_release", 64'(rv[0]), 64'd0);
    end

    // reset mid-EXEC drops the op
    hs(0, 1'b1, 32'd5, 32'd7);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("mid_rst_out", 64'({rv[0], rid[0], rres[0]}), 64'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 4; i++) begin tick(); if (rv[0]) seen++; end
      chk("mid_rst_no_rsp", 64'(seen), 64'd0);
    end
    op(0, 1'b0, 32'd3, 32'd4, 2, 40'h7);

    // ADD_CYCLES=3 latency and carry
    op(2, 1'b0, 32'h8000_0000, 32'h8000_0000, 3, 40'h01_0000_0000);
    op(2, 1'b1, 32'h1234_5678, 32'h1111_1111, 3, 40'h00_2345_6789);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
